button_debounce_ctrl: RTL
=========================

Name: button_debounce_ctrl

Overview:
- Multi-button debounce controller for the board I/O path.
- Generates one shared sample-tick enable internally, with no derived clock, and runs it from the system clock.
- On each tick, sequences debounce counting across all buttons.
- Queues press events and arbitrates them, lowest index first, to one consumer through a valid/ack handshake.

Parameters:
- N_BTN, 5, number of button inputs.
- TICK_DIV, 100000, system clocks per sample tick; must be at least 2.
- STABLE_CNT, 4, consecutive differing ticks required to accept a new level; must be at least 1.
- REPEAT_DELAY, 50, ticks held before the first auto-repeat; used only with the optional feature.
- REPEAT_PERIOD, 10, ticks between auto-repeats; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-low.
- btn_i  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- event_ack_i  in  1  consumer accepts the presented event.
- clr_ovr_i  in  1  clears all overrun flags.
- db_o  out  N_BTN  debounced level per button.
- rel_o  out  N_BTN  one-cycle release pulse per button.
- event_valid_o  out  1  a press event is being presented.
- event_id_o  out  $clog2(N_BTN)  index of the presented button.
- ovr_o  out  N_BTN  sticky: a press was lost because that button's event was still pending.
- tick_o  out  1  one-cycle sample-tick strobe, for debug and shared use.

Behaviour:
- Reset is asynchronous and active-low. Asserting rst at any time, including mid-event, clears immediately:
  - sync flops, tick counter, debounce counters and pending bits;
  - db_o, rel_o, ovr_o, tick_o and event_valid_o go to 0;
  - event_id_o goes to 0;
  - FSM goes to IDLE.
- Synchroniser: a 2-flop chain per bit. sync[i] lags btn_i by 2 clocks.
- Tick counter:
  - Counts 0..TICK_DIV-1.
  - tick_o = 1 for exactly the cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
  - The first tick occurs TICK_DIV clocks after reset release.
- Debounce, per button, evaluated only in tick cycles:
  - If sync[i] == db_o[i], cnt[i] is set to 0.
  - Otherwise cnt[i] increments.
  - When cnt[i]+1 == STABLE_CNT: db_o[i] takes sync[i] and cnt[i] is set to 0.
    - On a 0→1 change, pend[i] is set.
    - On a 1→0 change, rel_o[i] = 1 for the next single cycle.
  - Counter width is $clog2(STABLE_CNT+1). No wrap is possible.
- Pending rules:
  - A new press with pend[i] already 1 sets ovr_o[i]; the event is not duplicated.
  - ovr_o holds until clr_ovr_i; a set in the same cycle as clr_ovr_i wins.
  - A set of pend[i] in the same cycle as its clear by ack wins: the bit stays pending and ovr_o is not set.
- Event FSM:
  - IDLE: if any pend bit is set, register the lowest set index into event_id_o, set event_valid_o, and go to PRESENT.
  - PRESENT: event_id_o and event_valid_o are held stable. When event_ack_i = 1, clear pend[event_id_o], deassert event_valid_o the next cycle, and return to IDLE.
  - Result: at most one event per 2 clocks, with a guaranteed one-cycle gap of valid low between events.
  - event_ack_i is ignored in IDLE.
- Latency: a stable press reaches db_o[i] 2 + (up to TICK_DIV) × STABLE_CNT clocks after the edge. event_valid_o rises 1 clock after the pend bit is set, if the FSM is IDLE.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Enabled:
  - Each button has a hold counter counting ticks while db_o[i] = 1.
  - After REPEAT_DELAY ticks, and then every REPEAT_PERIOD ticks, pend[i] is set again, using the same overrun rules as a press.
  - The hold counter clears when db_o[i] falls.
- Disabled: no hold counters exist. One event is produced per debounced press.

Decomposition:
- Shared package btn_pkg holds:
  - the parameter defaults;
  - the FSM state typedef, with states IDLE and PRESENT;
  - a constant function computing the index width.
- One natural sub-module: tick_gen, holding the TICK_DIV counter and tick_o. It replaces ad-hoc divided clocks elsewhere in the design.

Test Plan:
All scenarios use TICK_DIV = 4 and STABLE_CNT = 3, with REPEAT parameters of 5/2 where used.
1. Reset, then idle for 40 clocks → tick_o pulses at clocks 4, 8, 12…; all outputs stay 0.
2. btn_i[2] bounces 1/0 every 3 clocks for 30 clocks, then holds 1 → db_o[2] rises only after 3 consecutive high ticks. event_valid_o = 1 with event_id_o = 2; no early events.
3. btn_i[1] and btn_i[3] are pressed together and the consumer acks in the cycle after valid → event id 1 is presented, then valid is low for 1 cycle, then id 3. No further events follow.
4. A press on button 0 is held without ack; release and press again → second press sets ovr_o[0]. There is only one pending event. clr_ovr_i clears ovr_o[0].
5. Release button 2 after the debounced press → rel_o[2] is high for exactly 1 cycle; no event is generated.
6. With BTN_AUTO_REPEAT_EN defined, hold button 4 → events at holds of 5, 7 and 9 ticks. A rst pulse mid-presentation drops event_valid_o asynchronously.

Source files
------------

// File: rtl/button_debounce_ctrl_pkg.sv
// Shared definitions for the button debounce controller: parameter
// defaults, the event FSM state type and the event index width helper.
package btn_pkg;

   localparam int N_BTN_DEF         = 5;
   localparam int TICK_DIV_DEF      = 100000;
   localparam int STABLE_CNT_DEF    = 4;
   localparam int REPEAT_DELAY_DEF  = 50;
   localparam int REPEAT_PERIOD_DEF = 10;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } evt_state_e;

   // Width of a button index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debounce_ctrl_tick_gen.sv
// Sample-tick generator: a free-running 0..TICK_DIV-1 counter on the system
// clock. tick_o is a one-cycle enable, never used as a clock.
module tick_gen
   import btn_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   // Count up and wrap to zero after the tick cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              cnt_q <= '0;
      else if (cnt_q == LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/button_debounce_ctrl.sv
// Multi-button debounce controller. Raw levels are synchronised, debounced
// on a shared sample tick, and press events are queued per button and
// presented lowest index first to a single consumer.
// Optional macro BTN_AUTO_REPEAT_EN adds per-button auto-repeat while held.
module button_debounce_ctrl
   import btn_pkg::*;
#(
   parameter int N_BTN         = N_BTN_DEF,
   parameter int TICK_DIV      = TICK_DIV_DEF,
   parameter int STABLE_CNT    = STABLE_CNT_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_BTN-1:0]              btn_i,
   input  logic                          event_ack_i,
   input  logic                          clr_ovr_i,
   output logic [N_BTN-1:0]              db_o,
   output logic [N_BTN-1:0]              rel_o,
   output logic                          event_valid_o,
   output logic [idx_width(N_BTN)-1:0]   event_id_o,
   output logic [N_BTN-1:0]              ovr_o,
   output logic                          tick_o
);

   localparam int IW = idx_width(N_BTN);
   localparam int CW = $clog2(STABLE_CNT + 1);

   if (TICK_DIV < 2 || STABLE_CNT < 1 || REPEAT_PERIOD < 1 ||
       REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
      $error("button_debounce_ctrl: illegal parameter set");
   end

   logic             tick;
   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [CW-1:0]    cnt_q [N_BTN];
   logic [N_BTN-1:0] db_q, rel_q, pend_q, ovr_q;
   logic [N_BTN-1:0] accept, press_set, pend_set, ack_clr;
   evt_state_e       state_q, state_d;
   logic [IW-1:0]    id_q, id_d, lowest;
   logic             ack_take;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   // Two-flop synchroniser per button.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // A button flips on the tick that completes STABLE_CNT differing samples.
   always_comb begin
      accept = '0;
      for (int i = 0; i < N_BTN; i++)
         accept[i] = tick && (sync2_q[i] != db_q[i]) &&
                     (cnt_q[i] == CW'(STABLE_CNT - 1));
      press_set = accept & sync2_q;
   end

   // Debounce counters, debounced level and one-cycle release pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
         db_q  <= '0;
         rel_q <= '0;
      end else begin
         rel_q <= '0;
         if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
               if (sync2_q[i] == db_q[i]) begin
                  cnt_q[i] <= '0;
               end else if (accept[i]) begin
                  cnt_q[i] <= '0;
                  db_q[i]  <= sync2_q[i];
                  rel_q[i] <= ~sync2_q[i];
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end
         end
      end
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int HW = $clog2(REPEAT_DELAY + 1);

   logic [HW-1:0]    hold_q [N_BTN];
   logic [N_BTN-1:0] rpt_set;

   // A repeat fires on the tick that brings the hold count to REPEAT_DELAY.
   always_comb begin
      rpt_set = '0;
      for (int i = 0; i < N_BTN; i++)
         rpt_set[i] = tick && db_q[i] && (hold_q[i] == HW'(REPEAT_DELAY - 1));
      pend_set = press_set | rpt_set;
   end

   // Hold counters: after a repeat, step back so the next one comes
   // REPEAT_PERIOD ticks later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (!db_q[i])
               hold_q[i] <= '0;
            else if (rpt_set[i])
               hold_q[i] <= HW'(REPEAT_DELAY - REPEAT_PERIOD);
            else if (tick)
               hold_q[i] <= hold_q[i] + 1'b1;
         end
      end
   end
`else
   // Only debounced presses raise events.
   always_comb begin
      pend_set = press_set;
   end
`endif

   // Decode the acknowledged event into a per-button clear.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < N_BTN; i++)
         ack_clr[i] = ack_take && (id_q == IW'(i));
   end

   // Pending and sticky overrun bits; a new set beats the ack clear, and an
   // overrun set beats clr_ovr_i.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
         ovr_q  <= '0;
      end else begin
         pend_q <= pend_set | (pend_q & ~ack_clr);
         ovr_q  <= (pend_set & pend_q & ~ack_clr) |
                   (ovr_q & ~{N_BTN{clr_ovr_i}});
      end
   end

   // Lowest-index pending button.
   always_comb begin
      lowest = '0;
      for (int i = N_BTN - 1; i >= 0; i--)
         if (pend_q[i]) lowest = IW'(i);
   end

   // Event FSM state and presented index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   // Handshake: event_valid_o is high exactly while PRESENT, with
   // event_id_o held stable; the event is consumed on a clock edge where
   // event_ack_i is high, after which valid stays low for at least one
   // cycle. event_ack_i has no effect while valid is low.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      ack_take = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pend_q) begin
               id_d    = lowest;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (event_ack_i) begin
               ack_take = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign db_o          = db_q;
   assign rel_o         = rel_q;
   assign ovr_o         = ovr_q;
   assign tick_o        = tick;
   assign event_valid_o = (state_q == PRESENT);
   assign event_id_o    = id_q;

endmodule
